alu_seq: RTL

Parametrised, handshaked successor to the single-cycle datapath ALU. It keeps the existing 4-bit control encodings for AND/OR/ADD/SUB/SLT/NOR, and adds shifts, unsigned SLT, signed overflow, and iterative multiply and divide (unsigned) with HI/LO results. It sits between the register-read stage and writeback in the multi-cycle core. The core stalls on in_ready/out_valid.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_muldiv_iter.sv | 86 ++++++++
 rtl/alu_seq.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_seq shared types: opcode encodings, FSM states, op classification.
// Imported by the ALU top and the iterative mul/div engine.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_XOR   = 4'b0011,
    OP_SLL   = 4'b0100,
    OP_SRL   = 4'b0101,
    OP_SUB   = 4'b0110,
    OP_SLT   = 4'b0111,
    OP_SLTU  = 4'b1000,
    OP_MULTU = 4'b1001,
    OP_DIVU  = 4'b1010,
    OP_NOR   = 4'b1100,
    OP_SRA   = 4'b1101
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  function automatic logic is_multicycle(logic [3:0] op);
    return (op == OP_MULTU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Shared iterative engine: shift-add MULTU, restoring DIVU, one bit/cycle.
// hi/lo present the values produced by the current iteration.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  logic             busy;
  logic             div_q;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_n;
  logic [WIDTH-1:0] lo_n;
  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   t;

  always_comb begin
    sh   = '0;
    diff = '0;
    t    = '0;
    hi_n = hi_q;
    lo_n = lo_q;
    if (div_q) begin
      // diff[WIDTH] is the borrow: set when the divisor does not fit
      sh   = {hi_q, lo_q[WIDTH-1]};
      diff = sh - {1'b0, m_q};
      if (!diff[WIDTH]) begin
        hi_n = diff[WIDTH-1:0];
        lo_n = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = sh[WIDTH-1:0];
        lo_n = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      t    = lo_q[0] ? ({1'b0, hi_q} + {1'b0, m_q})
                     : {1'b0, hi_q};
      hi_n = t[WIDTH:1];
      lo_n = {t[0], lo_q[WIDTH-1:1]};
    end
  end

  assign done = busy && (cnt == LAST);
  assign hi   = hi_n;
  assign lo   = lo_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      div_q <= 1'b0;
      cnt   <= '0;
      m_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      div_q <= div;
      cnt   <= '0;
      m_q   <= div ? b : a;
      lo_q  <= div ? a : b;
      hi_q  <= '0;
    end else if (busy) begin
      hi_q <= hi_n;
      lo_q <= lo_n;
      cnt  <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith/shift ops plus
// iterative MULTU/DIVU with HI/LO results.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [3:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state;
  state_e           state_n;
  logic             accept;
  logic             go_busy;
  logic             dz;
  logic             eng_done;
  logic [WIDTH-1:0] eng_hi;
  logic [WIDTH-1:0] eng_lo;
  logic [WIDTH-1:0] alu_r;
  logic [WIDTH-1:0] alu_h;
  logic             alu_ovf;
  logic             alu_dbz;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] dif;
  logic [SHW-1:0]   sh;

  assign sh = Y[SHW-1:0];
  assign dz = (control == OP_DIVU) && (Y == '0);
  // divide-by-zero bypasses the engine and completes like a 1-cycle op
  assign go_busy = accept && is_multicycle(control) && !dz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (accept)
          state_n = go_busy ? S_BUSY : S_DONE;
        else if (state == S_DONE && out_ready)
          state_n = S_IDLE;
      end
      S_BUSY: if (eng_done) state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE) ||
                (state == S_DONE && out_ready);
    out_valid = (state == S_DONE);
    accept    = in_valid && in_ready;
  end

  always_comb begin
    alu_r   = '0;
    alu_h   = '0;
    alu_ovf = 1'b0;
    alu_dbz = 1'b0;
    sum     = X + Y;
    dif     = X - Y;
    case (control)
      OP_AND:  alu_r = X & Y;
      OP_OR:   alu_r = X | Y;
      OP_XOR:  alu_r = X ^ Y;
      OP_NOR:  alu_r = ~(X | Y);
      OP_ADD: begin
        alu_r   = sum;
        alu_ovf = (X[WIDTH-1] == Y[WIDTH-1]) &&
                  (sum[WIDTH-1] != X[WIDTH-1]);
      end
      OP_SUB: begin
        alu_r   = dif;
        alu_ovf = (X[WIDTH-1] != Y[WIDTH-1]) &&
                  (dif[WIDTH-1] != X[WIDTH-1]);
      end
      OP_SLT:
        alu_r = {{(WIDTH-1){1'b0}}, $signed(X) < $signed(Y)};
      OP_SLTU:
        alu_r = {{(WIDTH-1){1'b0}}, X < Y};
      OP_SLL:  alu_r = X << sh;
      OP_SRL:  alu_r = X >> sh;
      OP_SRA:  alu_r = $unsigned($signed(X) >>> sh);
      OP_DIVU: begin
        alu_r   = '1;
        alu_h   = X;
        alu_dbz = 1'b1;
      end
      default: alu_r = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result      <= '0;
      result_hi   <= '0;
      zero        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (accept && !go_busy) begin
      result      <= alu_r;
      result_hi   <= alu_h;
      zero        <= (alu_r == '0);
      overflow    <= alu_ovf;
      div_by_zero <= alu_dbz;
    end else if (state == S_BUSY && eng_done) begin
      result      <= eng_lo;
      result_hi   <= eng_hi;
      zero        <= (eng_lo == '0);
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (go_busy),
    .div   (control == OP_DIVU),
    .a     (X),
    .b     (Y),
    .done  (eng_done),
    .hi    (eng_hi),
    .lo    (eng_lo)
  );

endmodule
